encdec_apb_master: RTL
======================

Name: encdec_apb_master

Overview:
- APB initiator that drives the EncDec register slave.
- Accepts one operation request from a host-side controller.
- Programs the four slave registers over APB, then waits for the slave's operation_done.
- Captures data_out and num_of_errors and returns them as a single result.
- Sits between test or system control logic and the EncDec APB slave port; it is the bus master that the register model responds to.

Parameters:
- DATA_WIDTH, 32, width of data_in/data_out payload.
- AMBA_ADDR_WIDTH, 20, width of PADDR.
- AMBA_WORD, 32, width of PWDATA.
- BASE_ADDR, 0, slave base address. Register offsets: CTRL +0x0, DATA_IN +0x4, CODEWORD_WIDTH +0x8, NOISE +0xC.
- TIMEOUT_CYCLES, 1024, done-wait limit; used only with the optional feature.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- cmd_op  in  2  CTRL[1:0]: 00 encode, 01 decode, 10 full channel, 11 forwarded unchanged.
- cmd_data  in  DATA_WIDTH  value for DATA_IN.
- cmd_width  in  2  CODEWORD_WIDTH[1:0]: 00=8, 01=16, 10=32.
- cmd_noise  in  DATA_WIDTH  value for NOISE.
- busy  out  1  high from the cycle after accepted start until result_valid.
- result_valid  out  1  one-cycle pulse when a result is available.
- result_data  out  DATA_WIDTH  captured data_out.
- result_nof  out  2  captured num_of_errors.
- result_timeout  out  1  high with result_valid if the done-wait expired.
- PADDR  out  AMBA_ADDR_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write; always 1 in this block.
- PWDATA  out  AMBA_WORD  APB write data.
- PREADY  in  1  slave ready; tie high if the slave has no wait states.
- operation_done  in  1  slave completion strobe.
- data_out  in  DATA_WIDTH  slave result data.
- num_of_errors  in  2  slave error count.

Behaviour:
- Reset (rst low, asynchronous):
  - Every output is 0: busy, result_valid, result_data, result_nof, result_timeout, PADDR, PSEL, PENABLE, PWRITE, PWDATA.
  - State returns to IDLE.
  - Reset mid-transfer abandons the transfer; no result is produced.
- Command capture: on start in IDLE, register all cmd_* inputs. Inputs changing afterwards have no effect.
- start outside IDLE is ignored and not queued.
- State sequence:
  - IDLE -> W_DATA -> W_WIDTH -> W_NOISE -> W_CTRL -> WAIT_DONE -> RESULT -> IDLE.
- Each W_* state is one APB write of two phases:
  - SETUP, 1 cycle: PSEL=1, PENABLE=0, PWRITE=1, PADDR=BASE_ADDR+offset, PWDATA=value.
  - ACCESS: PENABLE=1. PADDR, PWDATA and PWRITE are held until PREADY=1 is sampled, then advance to the next state.
  - Back-to-back writes return to SETUP with no idle cycle between them.
- Write values:
  - cmd_op and cmd_width are zero-extended to AMBA_WORD.
  - cmd_data and cmd_noise are zero-extended when DATA_WIDTH < AMBA_WORD.
- Write order is fixed: DATA_IN, CODEWORD_WIDTH, NOISE, CTRL. CTRL is always last because writing it triggers the slave.
- NOISE is written for every op, including encode.
- After the CTRL access completes: PSEL=0, PENABLE=0. PADDR and PWDATA hold their last values.
- WAIT_DONE: on operation_done=1, capture data_out into result_data and num_of_errors into result_nof, then go to RESULT.
- operation_done outside WAIT_DONE is ignored.
- RESULT: result_valid=1 for exactly 1 cycle, busy=0 in the same cycle. Next state IDLE.
- result_data and result_nof hold until the next capture or reset.
- Latency with PREADY tied 1: start at cycle 0, first SETUP at cycle 1, CTRL ACCESS at cycle 8, WAIT_DONE from cycle 9. result_valid occurs 1 cycle after operation_done is sampled.
- Each PREADY low cycle adds exactly one cycle.

Optional Feature:
- Macro: ENCDEC_DONE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_DONE and increments every cycle spent there.
  - If it reaches TIMEOUT_CYCLES before operation_done, go to RESULT with result_timeout=1, result_data=0, result_nof=0.
  - operation_done in the same cycle as expiry wins; result_timeout=0.
- Undefined: no counter. WAIT_DONE waits indefinitely. result_timeout is tied 0.

Test Plan:
- Encode, PREADY=1: cmd_op=00, cmd_data=0x0000_00A5, cmd_width=00. Required:
  - Writes 0x4=0xA5, 0x8=0x0, 0xC=noise, 0x0=0x0 in that order, each 2 cycles.
  - Model raises done 3 cycles later with data_out=0x0000_00F5 -> result_valid pulse, result_data=0xF5, result_nof=00.
- Full channel, 32-bit: cmd_op=10, cmd_width=10, cmd_noise=0x0000_0101, slave returns num_of_errors=10 -> result_nof=10, busy low in the result_valid cycle.
- Wait states: PREADY low for 3 cycles during the W_NOISE ACCESS -> PADDR=0xC and PWDATA held for 4 ACCESS cycles; total sequence 11 cycles to WAIT_DONE.
- Ignored events:
  - start pulsed in W_WIDTH -> no second transaction.
  - operation_done pulsed in W_DATA -> no capture.
  - Result comes from the later operation_done in WAIT_DONE.
- Reset: rst low during the W_CTRL ACCESS -> all outputs 0 immediately (asynchronous). After release, a new start runs the full sequence from DATA_IN.
- With ENCDEC_DONE_TIMEOUT_EN, TIMEOUT_CYCLES=16, no operation_done -> result_valid with result_timeout=1 exactly 16 cycles after entering WAIT_DONE.

Source files
------------

// File: rtl/encdec_apb_master_if.sv
// APB write-side bus between the EncDec initiator (master) and the register slave.
interface encdec_apb_master_if #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
);
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic                       PREADY;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PREADY
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PREADY
    );
endinterface

// File: rtl/encdec_apb_master.sv
// APB initiator: programs DATA_IN, CODEWORD_WIDTH, NOISE, CTRL, waits for operation_done, returns the result.
// Optional done-wait timeout enabled by defining ENCDEC_DONE_TIMEOUT_EN.
module encdec_apb_master #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int BASE_ADDR       = 0,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [1:0]            cmd_width,
    input  logic [DATA_WIDTH-1:0] cmd_noise,
    output logic                  busy,
    output logic                  result_valid,
    output logic [DATA_WIDTH-1:0] result_data,
    output logic [1:0]            result_nof,
    output logic                  result_timeout,
    encdec_apb_master_if.master   apb,
    input  logic                  operation_done,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic [1:0]            num_of_errors
);
    typedef enum logic [2:0] {
        S_IDLE, S_W_DATA, S_W_WIDTH, S_W_NOISE, S_W_CTRL, S_WAIT_DONE, S_RESULT
    } state_t;

    state_t                     r_state, w_state_next;
    logic [1:0]                 r_op, w_op_next;
    logic [DATA_WIDTH-1:0]      r_data, w_data_next;
    logic [1:0]                 r_width, w_width_next;
    logic [DATA_WIDTH-1:0]      r_noise, w_noise_next;
    logic [AMBA_ADDR_WIDTH-1:0] r_paddr, w_paddr_next;
    logic [AMBA_WORD-1:0]       r_pwdata, w_pwdata_next;
    logic                       r_psel, w_psel_next;
    logic                       r_penable, w_penable_next;
    logic                       r_pwrite, w_pwrite_next;
    logic [DATA_WIDTH-1:0]      r_res_data, w_res_data_next;
    logic [1:0]                 r_res_nof, w_res_nof_next;
    state_t                     w_adv;
`ifdef ENCDEC_DONE_TIMEOUT_EN
    logic [31:0]                r_cnt, w_cnt_next;
    logic                       r_res_to, w_res_to_next;
`endif

    function automatic logic [AMBA_ADDR_WIDTH-1:0] f_addr(input state_t s);
        int off;
        case (s)
            S_W_DATA:  off = 4;
            S_W_WIDTH: off = 8;
            S_W_NOISE: off = 12;
            default:   off = 0;
        endcase
        return AMBA_ADDR_WIDTH'(BASE_ADDR + off);
    endfunction

    function automatic logic [AMBA_WORD-1:0] f_wdata(input state_t s, input logic [1:0] op,
            input logic [DATA_WIDTH-1:0] data, input logic [1:0] width,
            input logic [DATA_WIDTH-1:0] noise);
        case (s)
            S_W_DATA:  return AMBA_WORD'(data);
            S_W_WIDTH: return AMBA_WORD'(width);
            S_W_NOISE: return AMBA_WORD'(noise);
            default:   return AMBA_WORD'(op);
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_data     <= '0;
            r_width    <= '0;
            r_noise    <= '0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_res_data <= '0;
            r_res_nof  <= '0;
`ifdef ENCDEC_DONE_TIMEOUT_EN
            r_cnt      <= '0;
            r_res_to   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_op       <= w_op_next;
            r_data     <= w_data_next;
            r_width    <= w_width_next;
            r_noise    <= w_noise_next;
            r_paddr    <= w_paddr_next;
            r_pwdata   <= w_pwdata_next;
            r_psel     <= w_psel_next;
            r_penable  <= w_penable_next;
            r_pwrite   <= w_pwrite_next;
            r_res_data <= w_res_data_next;
            r_res_nof  <= w_res_nof_next;
`ifdef ENCDEC_DONE_TIMEOUT_EN
            r_cnt      <= w_cnt_next;
            r_res_to   <= w_res_to_next;
`endif
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_op_next       = r_op;
        w_data_next     = r_data;
        w_width_next    = r_width;
        w_noise_next    = r_noise;
        w_paddr_next    = r_paddr;
        w_pwdata_next   = r_pwdata;
        w_psel_next     = r_psel;
        w_penable_next  = r_penable;
        w_pwrite_next   = r_pwrite;
        w_res_data_next = r_res_data;
        w_res_nof_next  = r_res_nof;
        w_adv           = state_t'(r_state + 3'd1);
`ifdef ENCDEC_DONE_TIMEOUT_EN
        w_cnt_next      = r_cnt;
        w_res_to_next   = r_res_to;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next   = S_W_DATA;
                    w_op_next      = cmd_op;
                    w_data_next    = cmd_data;
                    w_width_next   = cmd_width;
                    w_noise_next   = cmd_noise;
                    w_psel_next    = 1'b1;
                    w_penable_next = 1'b0;
                    w_pwrite_next  = 1'b1;
                    w_paddr_next   = f_addr(S_W_DATA);
                    w_pwdata_next  = f_wdata(S_W_DATA, cmd_op, cmd_data, cmd_width, cmd_noise);
                end
            end
            S_W_DATA, S_W_WIDTH, S_W_NOISE, S_W_CTRL: begin
                if (!r_penable) begin
                    w_penable_next = 1'b1;
                end else if (apb.PREADY) begin
                    w_penable_next = 1'b0;
                    if (r_state == S_W_CTRL) begin
                        // CTRL kicks the slave; release the bus but keep address/data visible.
                        w_state_next = S_WAIT_DONE;
                        w_psel_next  = 1'b0;
`ifdef ENCDEC_DONE_TIMEOUT_EN
                        w_cnt_next   = '0;
`endif
                    end else begin
                        w_state_next  = w_adv;
                        w_paddr_next  = f_addr(w_adv);
                        w_pwdata_next = f_wdata(w_adv, r_op, r_data, r_width, r_noise);
                    end
                end
            end
            S_WAIT_DONE: begin
                if (operation_done) begin
                    w_state_next    = S_RESULT;
                    w_res_data_next = data_out;
                    w_res_nof_next  = num_of_errors;
`ifdef ENCDEC_DONE_TIMEOUT_EN
                    w_res_to_next   = 1'b0;
                end else if (r_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    w_state_next    = S_RESULT;
                    w_res_data_next = '0;
                    w_res_nof_next  = '0;
                    w_res_to_next   = 1'b1;
                end else begin
                    w_cnt_next      = r_cnt + 32'd1;
`endif
                end
            end
            S_RESULT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    assign busy         = (r_state != S_IDLE) && (r_state != S_RESULT);
    assign result_valid = (r_state == S_RESULT);
    assign result_data  = r_res_data;
    assign result_nof   = r_res_nof;
`ifdef ENCDEC_DONE_TIMEOUT_EN
    assign result_timeout = r_res_to && result_valid;
`else
    assign result_timeout = 1'b0;
`endif
    assign apb.PADDR   = r_paddr;
    assign apb.PWDATA  = r_pwdata;
    assign apb.PSEL    = r_psel;
    assign apb.PENABLE = r_penable;
    assign apb.PWRITE  = r_pwrite;
endmodule
